// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: 8N1 UART receiver with framing-error detection.
// Define UART_RX_PARITY_EN to add a parity bit before the stop bit (ParityOdd, Rx_ParityError).
module uart_rx_deserializer #(
  parameter int ClocksPerBit = 10417
`ifdef UART_RX_PARITY_EN
  , parameter bit ParityOdd = 1'b0
`endif
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Rx,
  output logic [7:0] Rx_Data,
  output logic       Rx_DataValid,
  output logic       Rx_FrameError,
`ifdef UART_RX_PARITY_EN
  output logic       Rx_ParityError,
`endif
  output logic       Rx_Busy
);
  localparam int CntW = $clog2(ClocksPerBit);
  localparam logic [CntW-1:0] LP_HALF = CntW'((ClocksPerBit - 1) / 2);
  localparam logic [CntW-1:0] LP_LAST = CntW'(ClocksPerBit - 1);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_CLEAN, S_BREAK} state_t;
  localparam state_t S_AFTER_DATA =
`ifdef UART_RX_PARITY_EN
    S_PARITY;
`else
    S_STOP;
`endif
  state_t          r_state, w_next;
  logic            r_sync, r_rxs;
  logic [CntW-1:0] r_cnt;
  logic [2:0]      r_idx;
  logic [7:0]      r_shift;
  logic            w_tick, w_counting, w_data_tick, w_stop_tick;
`ifdef UART_RX_PARITY_EN
  logic            r_par_bad;
`endif
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = r_rxs ? S_IDLE : S_START;
      S_START:  w_next = !w_tick ? S_START : r_rxs ? S_IDLE : S_DATA;
      S_DATA:   w_next = (w_tick && r_idx == 3'd7) ? S_AFTER_DATA : S_DATA;
`ifdef UART_RX_PARITY_EN
      S_PARITY: w_next = w_tick ? S_STOP : S_PARITY;
`endif
      S_STOP:   w_next = !w_tick ? S_STOP : r_rxs ? S_CLEAN : S_BREAK;
      S_CLEAN:  w_next = S_IDLE;
      S_BREAK:  w_next = r_rxs ? S_IDLE : S_BREAK;
      default:  w_next = S_IDLE;
    endcase
  end
  // Start phase counts to the half-bit point; every later phase counts a full bit.
  always_comb begin
    w_counting  = r_state inside {S_START, S_DATA, S_PARITY, S_STOP};
    w_tick      = (r_state == S_START) ? (r_cnt == LP_HALF) : (r_cnt == LP_LAST);
    w_data_tick = (r_state == S_DATA) && w_tick;
    w_stop_tick = (r_state == S_STOP) && w_tick;
    Rx_Busy     = r_state != S_IDLE;
  end
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      r_sync        <= 1'b1;
      r_rxs         <= 1'b1;
      r_cnt         <= '0;
      r_idx         <= '0;
      r_shift       <= '0;
      Rx_Data       <= '0;
      Rx_DataValid  <= 1'b0;
      Rx_FrameError <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bad      <= 1'b0;
      Rx_ParityError <= 1'b0;
`endif
    end else begin
      r_sync        <= Rx;
      r_rxs         <= r_sync;
      // The falling-edge cycle itself counts as the first start-bit cycle.
      r_cnt         <= (r_state == S_IDLE) ? CntW'(!r_rxs) : (w_tick || !w_counting) ? '0 : r_cnt + 1'b1;
      r_idx         <= w_data_tick ? r_idx + 3'd1 : (r_state == S_IDLE) ? 3'd0 : r_idx;
      if (w_data_tick) r_shift[r_idx] <= r_rxs;
      if (w_stop_tick && r_rxs) Rx_Data <= r_shift;
      Rx_DataValid  <= w_stop_tick && r_rxs;
      Rx_FrameError <= w_stop_tick && !r_rxs;
`ifdef UART_RX_PARITY_EN
      if (r_state == S_PARITY && w_tick) r_par_bad <= r_rxs ^ (^r_shift) ^ ParityOdd;
      Rx_ParityError <= w_stop_tick && r_rxs && r_par_bad;
`endif
    end
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb_uart_rx_deserializer: directed tests for the UART receiver at 16 clocks per bit.
module tb_uart_rx_deserializer;
  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 170;
`else
  localparam int LAT = 154;
`endif
  logic       clk = 1'b0, rst = 1'b1, rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ferr, rx_busy;
  int         checks = 0, errors = 0, cyc = 0;
  int         n_valid = 0, n_ferr = 0, n_both = 0, last_valid_cyc = 0, last_ferr_cyc = 0, t_start = 0;
  logic [7:0] q_data[$];
`ifdef UART_RX_PARITY_EN
  logic       rx_perr;
  logic       par_flip = 1'b0;
  int         n_perr = 0, n_perr_lone = 0;
`endif

  uart_rx_deserializer #(.ClocksPerBit(CPB)) dut (
    .Clk(clk), .Rst(rst), .Rx(rx),
    .Rx_Data(rx_data), .Rx_DataValid(rx_valid), .Rx_FrameError(rx_ferr),
`ifdef UART_RX_PARITY_EN
    .Rx_ParityError(rx_perr),
`endif
    .Rx_Busy(rx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (!rst) begin
      if (rx_valid) begin
        n_valid++;
        q_data.push_back(rx_data);
        last_valid_cyc = cyc;
      end
      if (rx_ferr) begin
        n_ferr++;
        last_ferr_cyc = cyc;
      end
      if (rx_valid && rx_ferr) n_both++;
`ifdef UART_RX_PARITY_EN
      if (rx_perr) begin
        n_perr++;
        if (!rx_valid) n_perr_lone++;
      end
`endif
    end

  task automatic clear_mon();
    n_valid = 0; n_ferr = 0; n_both = 0;
    q_data.delete();
`ifdef UART_RX_PARITY_EN
    n_perr = 0; n_perr_lone = 0;
`endif
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    t_start = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ par_flip);
`endif
    send_bit(stop);
    rx = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
    checks++; if (rx_ferr !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", rx_ferr); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", rx_busy); end
    rst = 1'b0;
    idle(5);
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", rx_busy); end
  endtask

  task automatic test_frame();
    clear_mon();
    send_frame(8'h61, 1'b1);
    idle(4);
    checks++; if (n_valid !== 1) begin errors++; $display("FAIL frame_valid_count: got %0d expected 1", n_valid); end
    checks++; if (rx_data !== 8'h61) begin errors++; $display("FAIL frame_data: got %h expected 61", rx_data); end
    checks++; if (last_valid_cyc !== t_start + LAT) begin errors++; $display("FAIL frame_latency: got %0d expected %0d", last_valid_cyc - t_start, LAT); end
    checks++; if (n_ferr !== 0) begin errors++; $display("FAIL frame_ferr: got %0d expected 0", n_ferr); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL frame_busy_after: got %b expected 0", rx_busy); end
  endtask

  task automatic test_glitch();
    int c0;
    clear_mon();
    c0 = cyc;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx = 1'b1;
    do @(negedge clk); while (cyc < c0 + 9);
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_start: got %b expected 1", rx_busy); end
    @(negedge clk);
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_idle_t8: got %b expected 0", rx_busy); end
    idle(20);
    checks++; if (n_valid !== 0) begin errors++; $display("FAIL glitch_valid: got %0d expected 0", n_valid); end
    checks++; if (n_ferr !== 0) begin errors++; $display("FAIL glitch_ferr: got %0d expected 0", n_ferr); end
    checks++; if (rx_data !== 8'h61) begin errors++; $display("FAIL glitch_data_hold: got %h expected 61", rx_data); end
  endtask

  task automatic test_frame_error();
    clear_mon();
    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b0);
    idle(20);
    checks++; if (n_valid !== 1) begin errors++; $display("FAIL ferr_valid_count: got %0d expected 1", n_valid); end
    checks++; if (q_data.size() < 1 || q_data[0] !== 8'hA5) begin errors++; $display("FAIL ferr_first_data: got %h expected a5", q_data.size() ? q_data[0] : 8'hxx); end
    checks++; if (n_ferr !== 1) begin errors++; $display("FAIL ferr_count: got %0d expected 1", n_ferr); end
    checks++; if (last_ferr_cyc !== t_start + LAT) begin errors++; $display("FAIL ferr_latency: got %0d expected %0d", last_ferr_cyc - t_start, LAT); end
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL ferr_data_hold: got %h expected a5", rx_data); end
    checks++; if (n_both !== 0) begin errors++; $display("FAIL ferr_overlap: got %0d expected 0", n_both); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_after: got %b expected 0", rx_busy); end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(20);
    checks++; if (n_valid !== 2) begin errors++; $display("FAIL b2b_valid_count: got %0d expected 2", n_valid); end
    checks++; if (q_data.size() < 1 || q_data[0] !== 8'h00) begin errors++; $display("FAIL b2b_first: got %h expected 00", q_data.size() ? q_data[0] : 8'hxx); end
    checks++; if (q_data.size() < 2 || q_data[1] !== 8'hFF) begin errors++; $display("FAIL b2b_second: got %h expected ff", q_data.size() > 1 ? q_data[1] : 8'hxx); end
    checks++; if (last_valid_cyc !== t_start + LAT) begin errors++; $display("FAIL b2b_latency: got %0d expected %0d", last_valid_cyc - t_start, LAT); end
    checks++; if (n_ferr !== 0) begin errors++; $display("FAIL b2b_ferr: got %0d expected 0", n_ferr); end
  endtask

  task automatic test_reset_midframe();
    clear_mon();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rx = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b expected 1", rx_busy); end
    rst = 1'b1;
    #1;
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL mid_reset_data: got %h expected 00", rx_data); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b expected 0", rx_busy); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b expected 0", rx_valid); end
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(5);
    send_frame(8'h81, 1'b1);
    idle(20);
    checks++; if (n_valid !== 1) begin errors++; $display("FAIL mid_valid_count: got %0d expected 1", n_valid); end
    checks++; if (rx_data !== 8'h81) begin errors++; $display("FAIL mid_data: got %h expected 81", rx_data); end
    checks++; if (n_ferr !== 0) begin errors++; $display("FAIL mid_ferr: got %0d expected 0", n_ferr); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    clear_mon();
    par_flip = 1'b0;
    send_frame(8'h07, 1'b1);
    idle(10);
    checks++; if (n_valid !== 1) begin errors++; $display("FAIL par_good_valid: got %0d expected 1", n_valid); end
    checks++; if (n_perr !== 0) begin errors++; $display("FAIL par_good_perr: got %0d expected 0", n_perr); end
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1);
    idle(10);
    par_flip = 1'b0;
    checks++; if (n_valid !== 2) begin errors++; $display("FAIL par_bad_valid: got %0d expected 2", n_valid); end
    checks++; if (n_perr !== 1) begin errors++; $display("FAIL par_bad_perr: got %0d expected 1", n_perr); end
    checks++; if (n_perr_lone !== 0) begin errors++; $display("FAIL par_perr_align: got %0d expected 0", n_perr_lone); end
    checks++; if (rx_data !== 8'h07) begin errors++; $display("FAIL par_bad_data: got %h expected 07", rx_data); end
  endtask
`endif

  initial begin
    test_reset();
    test_frame();
    test_glitch();
    test_frame_error();
    test_back_to_back();
    test_reset_midframe();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
